// File: rtl/nn_mem_pkg.sv
// Shared constants for the feed-forward network memory subsystem:
// SRAM geometry, requester IDs and the data markers stored in weight/neuron tables.
package nn_mem_pkg;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;

    localparam int unsigned REQ_HOST  = 0;
    localparam int unsigned REQ_MULT  = 1;
    localparam int unsigned REQ_STORE = 2;

    localparam logic [DW-1:0] BIAS_MARK   = 32'h8000_0000;
    localparam logic [DW-1:0] NEURON_MARK = 32'hFFFF_FFFF;
    localparam logic [DW-1:0] END_MARK    = 32'hFFFF_FFF0;

    // True for words that delimit table sections rather than carry a value.
    function automatic logic is_marker(input logic [DW-1:0] w);
        return (w == BIAS_MARK) || (w == NEURON_MARK) || (w == END_MARK);
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant of the first request at or above ptr,
// wrapping at N, via a double-width masked priority encoder.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick
);

    localparam int unsigned W2 = 2 * N;

    logic [W2-1:0] dbl;
    logic [W2-1:0] mask;
    logic [W2-1:0] masked;
    logic          found;

    always_comb begin
        pick   = '0;
        found  = 1'b0;
        dbl    = {req, req};
        // Upper copy keeps everything so the search wraps back to requester 0.
        mask   = ~((W2'(1) << ptr) - W2'(1));
        masked = dbl & mask;
        for (int i = 0; i < int'(W2); i++) begin
            if (!found && masked[i]) begin
                found = 1'b1;
                if (i < int'(N)) begin
                    pick[i] = 1'b1;
                end else begin
                    pick[i - int'(N)] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: round-robin grant with a bounded lock for operand
// pairs, SRAM drive mux and one-cycle read-return routing by tag.
module sram_port_arbiter
    import nn_mem_pkg::*;
#(
    parameter int unsigned N        = 3,
    parameter int unsigned AW       = nn_mem_pkg::AW,
    parameter int unsigned DW       = nn_mem_pkg::DW,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    we,
    input  logic [N-1:0]    lock,
    input  logic [N*AW-1:0] adr,
    input  logic [N*DW-1:0] wdata,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    rvalid,
    output logic [DW-1:0]   rdata,
    output logic            sram_wr,
    output logic            sram_rd,
    output logic [AW-1:0]   sram_adr,
    output logic [DW-1:0]   sram_din,
    input  logic [DW-1:0]   sram_dout,
    output logic            busy
);

    localparam int unsigned PW = $clog2(N);
    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic          owner_vld_q, owner_vld_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] tag_q, tag_d;
    logic          tag_vld_q, tag_vld_d;

    logic [N-1:0]  rr_gnt;
    logic [N-1:0]  gnt_raw;
    logic          own_hit;
    logic          any_gnt;
    logic [PW-1:0] gidx;
    logic          g_lock;
    logic [CW-1:0] cnt_base;

    rr_pick #(.N(N), .PW(PW)) u_rr_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (rr_gnt)
    );

    // Grant and SRAM drive; everything forced idle while reset is held.
    always_comb begin
        own_hit  = owner_vld_q && req[owner_q];
        gnt_raw  = own_hit ? (N'(1) << owner_q) : rr_gnt;
        gnt      = rst ? gnt_raw : '0;
        any_gnt  = |gnt;
        gidx     = '0;
        g_lock   = 1'b0;
        sram_wr  = 1'b0;
        sram_rd  = 1'b0;
        sram_adr = '0;
        sram_din = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (gnt[i]) begin
                gidx     = PW'(i);
                g_lock   = lock[i];
                sram_wr  = we[i];
                sram_rd  = ~we[i];
                sram_adr = adr[i*AW +: AW];
                sram_din = wdata[i*DW +: DW];
            end
        end
    end

    // Lock/pointer bookkeeping and read tag capture.
    always_comb begin
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        tag_vld_d   = sram_rd;
        cnt_base    = own_hit ? cnt_q : '0;
        if (sram_rd) begin
            tag_d = gidx;
        end
        if (any_gnt) begin
            if (g_lock && ((32'(cnt_base) + 32'd1) < LOCK_MAX)) begin
                owner_d     = gidx;
                owner_vld_d = 1'b1;
                cnt_d       = cnt_base + CW'(1);
            end else begin
                owner_vld_d = 1'b0;
                cnt_d       = '0;
                ptr_d       = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
            end
        end else if (owner_vld_q && !req[owner_q]) begin
            owner_vld_d = 1'b0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            cnt_q       <= '0;
            tag_q       <= '0;
            tag_vld_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            tag_vld_q   <= tag_vld_d;
        end
    end

    // Return strobe is masked during reset so a read granted just before it is dropped.
    assign rvalid = (rst && tag_vld_q) ? (N'(1) << tag_q) : '0;
    assign rdata  = sram_dout;
    assign busy   = (|req) | tag_vld_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural registered-read SRAM.
module tb_sram_port_arbiter;
    import nn_mem_pkg::*;

    localparam int unsigned N = 3;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req, we, lock;
    logic [AW-1:0]   a0, a1, a2;
    logic [DW-1:0]   w0, w1, w2;
    logic [N*AW-1:0] adr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            sram_wr, sram_rd;
    logic [AW-1:0]   sram_adr;
    logic [DW-1:0]   sram_din;
    logic [DW-1:0]   sram_dout;
    logic            busy;

    int tests_run;
    int tests_failed;

    assign adr   = {a2, a1, a0};
    assign wdata = {w2, w1, w0};

    sram_port_arbiter #(.N(N), .AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .adr       (adr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .sram_wr   (sram_wr),
        .sram_rd   (sram_rd),
        .sram_adr  (sram_adr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: unwritten words read as 0xA0000000+addr, except word 5 = 1.0f.
    logic [DW-1:0] mem  [512];
    bit            wvld [512];
    always @(posedge clk) begin
        if (sram_wr) begin
            mem[sram_adr]  <= sram_din;
            wvld[sram_adr] <= 1'b1;
        end
        if (sram_rd) begin
            if (wvld[sram_adr])
                sram_dout <= mem[sram_adr];
            else if (sram_adr == 9'd5)
                sram_dout <= 32'h3F80_0000;
            else
                sram_dout <= 32'hA000_0000 + 32'(sram_adr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b0; req = '0; we = '0; lock = '0;
        a0 = '0; a1 = '0; a2 = '0; w0 = '0; w1 = '0; w2 = '0;
        sram_dout = '0;

        // Reset held with requests present: everything idle.
        req = 3'b111; a0 = 9'd7; a1 = 9'd7; a2 = 9'd7; w0 = 32'h1234_5678;
        settle();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rd", 32'(sram_rd), 32'h0);
        chk("rst_adr", 32'(sram_adr), 32'h0);
        chk("rst_din", sram_din, 32'h0);
        cyc();
        req = '0;
        settle();
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_wr", 32'(sram_wr), 32'h0);

        // Single read by requester 1 from address 5.
        cyc();
        rst = 1'b1; req = 3'b010; a1 = 9'd5;
        settle();
        chk("rd1_gnt", 32'(gnt), 32'h2);
        chk("rd1_sram_rd", 32'(sram_rd), 32'h1);
        chk("rd1_adr", 32'(sram_adr), 32'd5);
        cyc();
        req = '0;
        settle();
        chk("rd1_rvalid", 32'(rvalid), 32'h2);
        chk("rd1_rdata", rdata, 32'h3F80_0000);
        chk("rd1_gnt_idle", 32'(gnt), 32'h0);

        // Reset one cycle so round-robin starts at requester 0.
        cyc();
        rst = 1'b0;
        cyc();
        rst = 1'b1; req = 3'b111; a0 = 9'd1; a1 = 9'd2; a2 = 9'd3;
        settle();
        chk("rr_g0", 32'(gnt), 32'h1);
        chk("rr_rv0", 32'(rvalid), 32'h0);
        cyc();
        settle();
        chk("rr_g1", 32'(gnt), 32'h2);
        chk("rr_rv1", 32'(rvalid), 32'h1);
        chk("rr_rd1", rdata, 32'hA000_0001);
        cyc();
        settle();
        chk("rr_g2", 32'(gnt), 32'h4);
        chk("rr_rv2", 32'(rvalid), 32'h2);
        chk("rr_rd2", rdata, 32'hA000_0002);
        cyc();
        settle();
        chk("rr_g3", 32'(gnt), 32'h1);
        chk("rr_rv3", 32'(rvalid), 32'h4);
        chk("rr_rd3", rdata, 32'hA000_0003);
        cyc();
        req = '0;
        settle();
        chk("rr_rv4", 32'(rvalid), 32'h1);
        chk("rr_busy_tag", 32'(busy), 32'h1);
        cyc();
        settle();
        chk("rr_busy_idle", 32'(busy), 32'h0);

        // Lock pair: requester 1 holds the port for two reads while 2 waits.
        cyc();
        req = 3'b110; lock = 3'b010; a1 = 9'd10; a2 = 9'd30;
        settle();
        chk("lk_g0", 32'(gnt), 32'h2);
        cyc();
        a1 = 9'd200;
        settle();
        chk("lk_g1", 32'(gnt), 32'h2);
        chk("lk_rv1", 32'(rvalid), 32'h2);
        chk("lk_rd1", rdata, 32'hA000_000A);
        cyc();
        req = 3'b100; lock = '0;
        settle();
        chk("lk_g2", 32'(gnt), 32'h4);
        chk("lk_rv2", 32'(rvalid), 32'h2);
        chk("lk_rd2", rdata, 32'hA000_00C8);
        cyc();
        req = '0;
        settle();
        chk("lk_rv3", 32'(rvalid), 32'h4);
        chk("lk_rd3", rdata, 32'hA000_001E);

        // Lock limit: four locked grants to 0, forced release to 2, then 0 again.
        cyc();
        req = 3'b101; lock = 3'b001; a0 = 9'd0; a2 = 9'd3;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("ll_g0_%0d", k), 32'(gnt), 32'h1);
            cyc();
        end
        settle();
        chk("ll_release", 32'(gnt), 32'h4);
        cyc();
        settle();
        chk("ll_back0", 32'(gnt), 32'h1);
        cyc();
        req = '0; lock = '0;
        settle();
        chk("ll_rv_last", 32'(rvalid), 32'h1);

        // Write by requester 2, then read back by 0; lock without req is ignored.
        cyc();
        req = 3'b100; we = 3'b100; a2 = 9'd40; w2 = 32'h4049_0FDB;
        settle();
        chk("wr_gnt", 32'(gnt), 32'h4);
        chk("wr_sram_wr", 32'(sram_wr), 32'h1);
        chk("wr_sram_rd", 32'(sram_rd), 32'h0);
        chk("wr_din", sram_din, 32'h4049_0FDB);
        chk("wr_adr", 32'(sram_adr), 32'd40);
        cyc();
        req = 3'b001; we = '0; a0 = 9'd40; lock = 3'b010;
        settle();
        chk("wr_no_rvalid", 32'(rvalid), 32'h0);
        chk("rb_gnt", 32'(gnt), 32'h1);
        cyc();
        req = '0; lock = '0;
        settle();
        chk("rb_rvalid", 32'(rvalid), 32'h1);
        chk("rb_rdata", rdata, 32'h4049_0FDB);
        chk("lk_noreq_gnt", 32'(gnt), 32'h0);

        // Reset right after a read grant: return dropped, pointer back to 0.
        cyc();
        req = 3'b001; a0 = 9'd5;
        settle();
        chk("mr_gnt", 32'(gnt), 32'h1);
        cyc();
        rst = 1'b0; req = 3'b010;
        settle();
        chk("mr_rvalid", 32'(rvalid), 32'h0);
        chk("mr_gnt_rst", 32'(gnt), 32'h0);
        cyc();
        rst = 1'b1; req = 3'b011;
        settle();
        chk("mr_ptr0", 32'(gnt), 32'h1);
        chk("mr_rvalid2", 32'(rvalid), 32'h0);
        cyc();
        req = '0;
        settle();
        chk("mr_rv_after", 32'(rvalid), 32'h1);
        chk("mr_rdata", rdata, 32'h3F80_0000);
        chk("marker_fn", 32'(is_marker(END_MARK)), 32'h1);

        cyc();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
